instr_queue: RTL
================

# instr_queue

In-order instruction FIFO between the instruction fetch unit (writer) and decode/dispatch (reader). It accepts one fetched instruction per cycle while not full and presents the oldest entry to the reader with a valid/dequeue handshake. It tracks entries fetched speculatively after an issued branch. On a branch misprediction it squashes exactly those still-queued entries, so fetch can restart on the not-taken path.

## Interface
- DEPTH, 8, number of entries; power of two, at least 2
- WIDTH, 32, instruction width; word32_t when 32
- clk_i  in  1  clock; all state updates on the rising edge
- reset_ni  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- iq_write_i  in  1  fetch write strobe
- instr_i  in  WIDTH  instruction to enqueue
- issuing_branch_i  in  1  the entry written this cycle is a conditional branch; opens a speculation window
- iq_full_o  out  1  queue full; fetch must not write
- cond_eval_i  in  1  branch ALU resolved the outstanding branch this cycle
- corr_pred_i  in  1  qualifies cond_eval_i: 1 means correct prediction, 0 means mispredict
- deq_i  in  1  reader consumes the head entry
- valid_o  out  1  head entry valid (queue not empty)
- instr_o  out  WIDTH  head instruction; 0 when valid_o=0
- instr_spec_o  out  1  head entry is speculative (younger than the unresolved branch)
- count_o  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH×WIDTH array with no reset. Read pointer and write pointer are $clog2(DEPTH) bits each and wrap modulo DEPTH. Occupancy count ranges 0..DEPTH.
- Write is accepted when iq_write_i=1, count<DEPTH and no mispredict this cycle. instr_i goes to mem[wr_ptr], then wr_ptr+1.
- Read is accepted when deq_i=1 and count>0: rd_ptr+1. deq_i while empty is ignored. There is no write-to-read bypass.
- Speculation state: spec_active flag and young_cnt (same width as count).
  - Accepted write with issuing_branch_i=1: spec_active<=1, young_cnt<=0. The branch itself is not young.
  - Accepted write with spec_active=1 and no branch: young_cnt increments.
  - Accepted read while young_cnt==count (head is young): young_cnt decrements.
  - instr_spec_o = valid_o & spec_active & (young_cnt==count).
- Correct resolution (cond_eval_i & corr_pred_i): spec_active<=0 and young_cnt<=0, unless a branch is accepted in the same cycle. In that case spec_active stays 1 and young_cnt<=0.
- Mispredict (cond_eval_i & ~corr_pred_i):
  - wr_ptr<=wr_ptr−young_cnt' and count<=count'−young_cnt', where ' is the value after any same-cycle read.
  - spec_active<=0, young_cnt<=0.
  - A same-cycle iq_write_i is discarded.
  - A same-cycle read proceeds. If that read consumed a young entry, it is no longer counted as squashed; downstream owns it.
- cond_eval_i with spec_active=0 is ignored. issuing_branch_i while spec_active=1 with no same-cycle resolution is a protocol violation; the bench asserts on it.
- Reset (async, any time): rd_ptr=wr_ptr=0, count=0, spec_active=0, young_cnt=0. Memory contents are don't-care.

## Timing
- Reset values: iq_full_o=0, valid_o=0, instr_o=0, instr_spec_o=0, count_o=0.
- All outputs are combinational from registered state, with no input-to-output paths.
- Write-to-read latency is 1 cycle: a write at edge N gives valid_o=1 with that instruction after edge N.
- iq_full_o asserts the cycle after the write that makes count=DEPTH. It deasserts the cycle after a read from full.
- Simultaneous read and write at 0<count<DEPTH: count unchanged; both pointers advance.
- When full, a write is refused even with a same-cycle read. Fetch sees iq_full_o and holds its PC.
- Squash takes effect on the resolution edge. Next cycle, count_o and iq_full_o reflect post-squash occupancy. A write the following cycle lands at the restored wr_ptr.

## Test plan
- Fill/drain and wrap: 12 writes of 0x100+i with deq_i alternating. Every instruction emerges in order. iq_full_o is 1 only at count=8. Pointers wrap past index 7 with no loss.
- Full/empty edges: write 8 entries, then 9th iq_write_i with deq_i=0. count_o stays 8 and the 9th value never appears. Then deq_i on empty: count_o stays 0 and instr_o=0.
- Mispredict squash:
  - Write A, B, branch BR (issuing_branch_i), then Y1, Y2, Y3; no reads; then cond_eval_i=1, corr_pred_i=0.
  - Next cycle count_o=3 and the queue holds A, B, BR.
  - A new write C lands after BR; dequeued order is A, B, BR, C.
- Correct prediction: same stimulus with corr_pred_i=1. count_o=6, all entries retained, instr_spec_o=0 for every entry after resolution.
- Partial consumption plus squash: write BR, Y1, Y2. Dequeue BR and Y1; instr_spec_o=1 while Y1 is head. Then mispredict in the same cycle as deq of Y2. Next cycle count_o=0 and valid_o=0.
- Async reset mid-operation: with count=5 and spec_active=1, pulse reset_ni low between edges. All outputs go to reset values immediately, without waiting for a clock edge. A write after release appears at count_o=1.

Source files
------------

// File: rtl/instr_queue.sv
// In-order fetch->decode instruction FIFO that tracks entries fetched after an
// unresolved branch and squashes them from the tail on a misprediction.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       iq_write_i,
  input  logic [WIDTH-1:0]           instr_i,
  input  logic                       issuing_branch_i,
  output logic                       iq_full_o,
  input  logic                       cond_eval_i,
  input  logic                       corr_pred_i,
  input  logic                       deq_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           instr_o,
  output logic                       instr_spec_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d, young_q, young_d;
  logic             spec_q, spec_d;

  logic             full, empty, head_young, mispredict, resolve_ok, wr_acc, rd_acc;
  logic [CW-1:0]    cnt_rd, young_rd;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  // Young entries always form the tail, so the head is young only when all are.
  assign head_young = spec_q & (young_q == count_q);
  assign mispredict = cond_eval_i & ~corr_pred_i & spec_q;
  assign resolve_ok = cond_eval_i &  corr_pred_i & spec_q;
  assign wr_acc     = iq_write_i & ~full & ~mispredict;
  assign rd_acc     = deq_i & ~empty;

  assign cnt_rd   = count_q - CW'(rd_acc);
  assign young_rd = young_q - CW'(rd_acc & head_young);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    count_d  = cnt_rd + CW'(wr_acc);
    spec_d   = spec_q;
    young_d  = young_rd;
    if (mispredict) begin
      // A young entry consumed this cycle belongs to downstream, not the squash.
      wr_ptr_d = wr_ptr_q - young_rd[PW-1:0];
      count_d  = cnt_rd - young_rd;
      spec_d   = 1'b0;
      young_d  = '0;
    end else begin
      if (resolve_ok) begin
        spec_d  = 1'b0;
        young_d = '0;
      end
      if (wr_acc) begin
        if (issuing_branch_i) begin
          spec_d  = 1'b1;
          young_d = '0;
        end else if (spec_d) begin
          young_d = young_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      young_q  <= '0;
      spec_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      young_q  <= young_d;
      spec_q   <= spec_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= instr_i;
  end

  assign valid_o      = ~empty;
  assign instr_o      = empty ? '0 : mem_q[rd_ptr_q];
  assign instr_spec_o = ~empty & head_young;
  assign iq_full_o    = full;
  assign count_o      = count_q;
endmodule
